wavegen_pwm: RTL and testbench
==============================

Name: wavegen_pwm

Overview:
- Parametrised successor to the fixed single-output wave generator.
- Produces one waveform output with programmable period and high time, width set by `CNT_W`.
- Three run modes: continuous, N-pulse burst, one-shot.
- Configuration is loaded through a valid/ready handshake into shadow registers. Changes are applied glitch-free at period boundaries. The block sits between the control register bank and the output pin logic.

Parameters:
- CNT_W, 16, width of the period and high-time counters.
- BURST_W, 8, width of the burst length and pulse counter.
- IDLE_LVL, 1'b0, level of `wave` when not active; the active level is ~IDLE_LVL.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; low aborts a run.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted.
- cfg_mode  in  2  0=off, 1=continuous, 2=burst, 3=one-shot.
- cfg_period  in  CNT_W  period in clk cycles.
- cfg_high  in  CNT_W  active-level cycles per period.
- cfg_burst  in  BURST_W  pulses per burst (mode 2).
- start  in  1  start request, single-cycle pulse or level.
- wave  out  1  registered waveform.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on normal burst/one-shot completion.
- pulse_cnt  out  BURST_W  periods completed in current run.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - wave=IDLE_LVL, busy=0, done=0, cfg_ready=1, pulse_cnt=0;
  - active config mode/period/high/burst all 0, pending flag 0;
  - counter 0, state IDLE.
- Reset deasserted mid-run: the block restarts in IDLE; no done is generated.
- States: IDLE, RUN. busy=1 exactly in RUN.
- Config handshake:
  - A transfer occurs when cfg_valid && cfg_ready; the values are latched into a pending register.
  - cfg_ready = !pending.
  - In IDLE, pending is applied to the active config at the next clock, so cfg_ready recovers after one cycle.
  - In RUN, pending is applied at the next period boundary only.
- Start:
  - IDLE->RUN when start && en && active mode!=0 && active period!=0.
  - A config accepted in the same cycle as start is applied first, and start is evaluated against it.
  - On entry: counter=0, pulse_cnt=0.
  - start while in RUN is ignored. start with mode 0 or period 0 is ignored.
- Counter (RUN):
  - The counter runs 0..period-1, then wraps to 0; the wrap cycle is the period boundary.
  - wave is registered: in each RUN cycle, wave = (counter < high) ? ~IDLE_LVL : IDLE_LVL.
  - The first active cycle is the first clock after start is accepted.
  - high=0 gives a constant IDLE_LVL; high>=period gives a constant active level.
- Period boundary:
  - pulse_cnt increments. In mode 1 it wraps modulo 2^BURST_W.
  - Pending config, if any, is applied.
  - New period=0 or new mode=0 -> IDLE with no done.
- Burst (mode 2):
  - At the boundary where the post-increment pulse_cnt equals burst, the block goes to IDLE and done=1 for exactly one cycle.
  - cfg_burst=0 is treated as 1.
- One-shot (mode 3): identical to burst with burst length 1.
- Abort: en=0 in RUN -> IDLE on the next clock. wave=IDLE_LVL and busy=0 in that same cycle; no done; pulse_cnt holds its value.
- IDLE outputs: wave=IDLE_LVL; pulse_cnt holds the last run's count until the next start.
- Simultaneous boundary completion and en=0: abort wins and done stays 0.
- Width rules: all comparisons are unsigned at CNT_W; there is no truncation of the cfg inputs.

Test Plan:
- Clock period 20 ns throughout.
- Reset: drive rst=0 for 2 cycles mid-run -> wave=0, busy=0, cfg_ready=1, pulse_cnt=0 immediately, without waiting for a clock edge.
- Continuous: cfg mode=1 period=5 high=2, start -> wave repeats 1,1,0,0,0 from the cycle after start; pulse_cnt=4 after 20 cycles; done never asserts.
- Burst: mode=2 period=4 high=1 burst=3 -> exactly 3 pulses; done high for 1 cycle at the 12th RUN cycle boundary; then busy=0 and pulse_cnt=3.
- Reconfig mid-run: in mode 1 with period=8 high=4, load period=4 high=1 at counter=2 -> cfg_ready=0 until the boundary; the first period completes as 4 high and 4 low, then the new 1-high/3-low pattern follows; cfg_ready returns to 1.
- Edge duties: high=0 -> wave constantly 0 while busy=1. high=10 with period=6 -> wave constantly 1. period=0 with start -> stays IDLE.
- Abort: deassert en during the second pulse of burst=5 -> next cycle busy=0, wave=0, done=0, pulse_cnt=1.

Source files
------------

// File: rtl/wavegen_pwm_if.sv
// Configuration channel of the PWM wave generator: valid/ready handshake carrying
// mode, period, high time and burst length.
interface wavegen_pwm_if #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
);
    logic               valid;
    logic               ready;
    logic [1:0]         mode;
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   high;
    logic [BURST_W-1:0] burst;

    modport master (output valid, mode, period, high, burst, input ready);
    modport slave  (input valid, mode, period, high, burst, output ready);
endinterface

// File: rtl/wavegen_pwm.sv
// PWM waveform generator with continuous, burst and one-shot runs; configuration is
// shadowed in a pending register and swapped in only at period boundaries.
module wavegen_pwm #(
    parameter int   CNT_W    = 16,
    parameter int   BURST_W  = 8,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    wavegen_pwm_if.slave       cfg,
    output logic               wave,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] pulse_cnt
);
    localparam logic ACT_LVL = ~IDLE_LVL;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [1:0]         mode;
        logic [CNT_W-1:0]   period;
        logic [CNT_W-1:0]   high;
        logic [BURST_W-1:0] burst;
    } cfg_t;

    state_t             state;
    cfg_t               act, pend, in_cfg, sel_cfg;
    logic               pending;
    logic [CNT_W-1:0]   cnt, cnt_inc;
    logic               xfer, last, go, finish;
    logic [BURST_W-1:0] pulse_nxt, burst_len;

    assign cfg.ready = !pending;
    assign xfer      = cfg.valid && !pending;
    assign in_cfg    = '{mode: cfg.mode, period: cfg.period, high: cfg.high, burst: cfg.burst};

    // NOTE: every always_comb output is assigned a default first so no latch can be inferred.
    always_comb begin
        sel_cfg = pending ? pend : act;
        // A config offered together with start in IDLE is the one that start is judged against.
        if (state == IDLE && xfer && start) sel_cfg = in_cfg;
        go        = start && en && (sel_cfg.mode != 2'd0) && (sel_cfg.period != '0);
        last      = (cnt == act.period - CNT_W'(1));
        cnt_inc   = cnt + CNT_W'(1);
        pulse_nxt = pulse_cnt + BURST_W'(1);
        case (sel_cfg.mode)
            2'd2:    burst_len = (sel_cfg.burst == '0) ? BURST_W'(1) : sel_cfg.burst;
            2'd3:    burst_len = BURST_W'(1);
            default: burst_len = '0;
        endcase
        finish = sel_cfg.mode[1] && (pulse_nxt == burst_len);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            act       <= '0;
            pend      <= '0;
            pending   <= 1'b0;
            cnt       <= '0;
            pulse_cnt <= '0;
            wave      <= IDLE_LVL;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    wave <= IDLE_LVL;
                    if (xfer && !start) begin
                        pend    <= in_cfg;
                        pending <= 1'b1;
                    end else begin
                        act     <= sel_cfg;
                        pending <= 1'b0;
                    end
                    if (go) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        pulse_cnt <= '0;
                        wave      <= (sel_cfg.high != '0) ? ACT_LVL : IDLE_LVL;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        pend    <= in_cfg;
                        pending <= 1'b1;
                    end
                    if (!en) begin
                        // Abort beats a coincident boundary: no count, no done.
                        state <= IDLE;
                        busy  <= 1'b0;
                        wave  <= IDLE_LVL;
                    end else if (!last) begin
                        cnt  <= cnt_inc;
                        wave <= (cnt_inc < act.high) ? ACT_LVL : IDLE_LVL;
                    end else begin
                        if (pending) begin
                            act     <= pend;
                            pending <= 1'b0;
                        end
                        cnt       <= '0;
                        pulse_cnt <= pulse_nxt;
                        if (sel_cfg.mode == 2'd0 || sel_cfg.period == '0 || finish) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            wave  <= IDLE_LVL;
                            done  <= finish && (sel_cfg.period != '0);
                        end else begin
                            wave <= (sel_cfg.high != '0) ? ACT_LVL : IDLE_LVL;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wavegen_pwm.sv
// Scoreboard bench for wavegen_pwm: scenarios push per-cycle expectations computed
// from period/high arithmetic; a negedge monitor pops and compares them.
module tb_wavegen_pwm;
    localparam int CNT_W   = 16;
    localparam int BURST_W = 8;

    logic               clk   = 1'b0;
    logic               rst   = 1'b0;
    logic               en    = 1'b0;
    logic               start = 1'b0;
    logic               wave, busy, done;
    logic [BURST_W-1:0] pulse_cnt;

    wavegen_pwm_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) cfg_if ();

    wavegen_pwm #(.CNT_W(CNT_W), .BURST_W(BURST_W), .IDLE_LVL(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .cfg       (cfg_if.slave),
        .wave      (wave),
        .busy      (busy),
        .done      (done),
        .pulse_cnt (pulse_cnt)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        string      tag;
        bit         wave;
        bit         busy;
        bit         done;
        bit         rdy;
        logic [7:0] pc;
    } exp_t;

    exp_t       sb[$];
    int         seg_per[$];
    int         seg_hi[$];
    logic [7:0] last_pc  = 8'd0;
    int         n_checks = 0;
    int         n_err    = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic push_item(input int t, input string tag, input bit w, input bit b,
                             input bit d, input bit r, input logic [7:0] pc);
        exp_t e;
        e.cyc = t; e.tag = tag; e.wave = w; e.busy = b; e.done = d; e.rdy = r; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic set_segs(input int n, input int per, input int hi);
        seg_per.delete();
        seg_hi.delete();
        for (int i = 0; i < n; i++) begin
            seg_per.push_back(per);
            seg_hi.push_back(hi);
        end
    endtask

    // Reference: RUN cycle k inside period p at offset c shows wave=(c<high), pulse_cnt=p.
    // end_kind: 0 = open-ended, 1 = completes with done, 2 = stops silently.
    task automatic push_trace(input string tag, input int t0, input int abort_k, input int end_kind,
                              input int cut_k, input int rdy_lo, input int rdy_hi);
        int         k    = 0;
        logic [7:0] prev = 8'd0;
        for (int p = 0; p < seg_per.size(); p++) begin
            for (int c = 0; c < seg_per[p]; c++) begin
                if (k == cut_k) return;
                if (k == abort_k) begin
                    last_pc = prev;
                    push_item(t0 + k, tag, 1'b0, 1'b0, 1'b0, 1'b1, prev);
                    push_item(t0 + k + 1, tag, 1'b0, 1'b0, 1'b0, 1'b1, prev);
                    return;
                end
                prev = 8'(p);
                push_item(t0 + k, tag, c < seg_hi[p], 1'b1, 1'b0, !(k >= rdy_lo && k <= rdy_hi), prev);
                k++;
            end
        end
        if (k == cut_k) return;
        if (k == abort_k) begin
            last_pc = prev;
            push_item(t0 + k, tag, 1'b0, 1'b0, 1'b0, 1'b1, prev);
            push_item(t0 + k + 1, tag, 1'b0, 1'b0, 1'b0, 1'b1, prev);
        end else if (end_kind != 0) begin
            last_pc = 8'(seg_per.size());
            push_item(t0 + k, tag, 1'b0, 1'b0, end_kind == 1, 1'b1, last_pc);
            push_item(t0 + k + 1, tag, 1'b0, 1'b0, 1'b0, 1'b1, last_pc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick();
    endtask

    task automatic load_cfg(input logic [1:0] mode, input int per, input int hi, input int burst);
        int guard = 0;
        cfg_if.valid  = 1'b1;
        cfg_if.mode   = mode;
        cfg_if.period = CNT_W'(per);
        cfg_if.high   = CNT_W'(hi);
        cfg_if.burst  = BURST_W'(burst);
        while (!cfg_if.ready && guard < 20) begin
            tick();
            guard++;
        end
        check("cfg_ready_wait", 32'(cfg_if.ready), 32'd1);
        tick();
        cfg_if.valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_fixed(input string tag, input logic [1:0] mode, input int per, input int hi,
                             input int burst, input int abort_k);
        int n, t0, end_t, ak;
        load_cfg(mode, per, hi, burst);
        tick();
        n  = (mode == 2'd1) ? (abort_k / per + 2) : (mode == 2'd3) ? 1 : ((burst == 0) ? 1 : burst);
        ak = (abort_k > n * per) ? -1 : abort_k;
        set_segs(n, per, hi);
        t0 = cyc + 1;
        push_trace(tag, t0, ak, (mode == 2'd1) ? 0 : 1, -1, -1, -2);
        pulse_start();
        if (ak >= 1) begin
            wait_cyc(t0 + ak - 1);
            en = 1'b0;
            tick();
            en = 1'b1;
        end
        end_t = (ak >= 1) ? ak : n * per;
        wait_cyc(t0 + end_t + 3);
    endtask

    task automatic idle_start(input string tag);
        int t0 = cyc + 1;
        for (int i = 0; i < 4; i++) push_item(t0 + i, tag, 1'b0, 1'b0, 1'b0, 1'b1, last_pc);
        pulse_start();
        wait_cyc(t0 + 5);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc != cyc) check($sformatf("%s@%0d_late", e.tag, e.cyc), 32'(cyc), 32'(e.cyc));
                check($sformatf("%s@%0d_out", e.tag, e.cyc), 32'({wave, busy, done, pulse_cnt}),
                      32'({e.wave, e.busy, e.done, e.pc}));
                check($sformatf("%s@%0d_rdy", e.tag, e.cyc), 32'(cfg_if.ready), 32'(e.rdy));
            end
        end
    end

    initial begin
        int t0, guard, mode, per, hi, burst, n, ak;
        cfg_if.valid  = 1'b0;
        cfg_if.mode   = '0;
        cfg_if.period = '0;
        cfg_if.high   = '0;
        cfg_if.burst  = '0;

        #5;
        check("rst_wave", 32'(wave), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(cfg_if.ready), 32'd1);
        check("rst_pc", 32'(pulse_cnt), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        en  = 1'b1;
        tick();

        idle_start("mode0_start");
        run_fixed("continuous", 2'd1, 5, 2, 0, 23);
        run_fixed("burst3", 2'd2, 4, 1, 3, -1);
        run_fixed("high0", 2'd1, 5, 0, 0, 12);
        run_fixed("high_over", 2'd1, 6, 10, 0, 14);
        run_fixed("abort_burst5", 2'd2, 4, 1, 5, 5);
        run_fixed("oneshot", 2'd3, 6, 3, 7, -1);
        run_fixed("burst0_as1", 2'd2, 3, 2, 0, -1);

        load_cfg(2'd1, 0, 3, 0);
        tick();
        idle_start("period0_start");

        // Reconfiguration during the first period of a continuous run.
        load_cfg(2'd1, 8, 4, 0);
        tick();
        seg_per = '{8, 4, 4, 4, 4};
        seg_hi  = '{4, 1, 1, 1, 1};
        t0 = cyc + 1;
        push_trace("reconfig", t0, 21, 0, -1, 3, 7);
        pulse_start();
        wait_cyc(t0 + 2);
        load_cfg(2'd1, 4, 1, 0);
        wait_cyc(t0 + 20);
        en = 1'b0;
        tick();
        en = 1'b1;
        wait_cyc(t0 + 24);

        // Mode 0 loaded mid-burst ends the run at the boundary without done.
        load_cfg(2'd2, 3, 1, 4);
        tick();
        set_segs(1, 3, 1);
        t0 = cyc + 1;
        push_trace("mode0_reload", t0, -1, 2, -1, 2, 2);
        pulse_start();
        wait_cyc(t0 + 1);
        load_cfg(2'd0, 3, 1, 4);
        wait_cyc(t0 + 6);

        for (int it = 0; it < 8; it++) begin
            mode  = int'($urandom_range(1, 3));
            per   = int'($urandom_range(1, 9));
            hi    = int'($urandom_range(0, 11));
            burst = int'($urandom_range(0, 4));
            n     = (mode == 3) ? 1 : ((burst == 0) ? 1 : burst);
            if (mode == 1) ak = int'($urandom_range(1, 30));
            else ak = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n * per)) : -1;
            run_fixed($sformatf("rand%0d_m%0d_p%0d_h%0d_b%0d", it, mode, per, hi, burst),
                      2'(mode), per, hi, burst, ak);
        end

        // Asynchronous reset in the middle of a continuous run.
        load_cfg(2'd1, 5, 2, 0);
        tick();
        set_segs(3, 5, 2);
        t0 = cyc + 1;
        push_trace("pre_reset", t0, -1, 0, 5, -1, -2);
        pulse_start();
        wait_cyc(t0 + 5);
        #4;
        rst = 1'b0;
        #1;
        check("midrst_wave", 32'(wave), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_ready", 32'(cfg_if.ready), 32'd1);
        check("midrst_pc", 32'(pulse_cnt), 32'd0);
        tick();
        tick();
        rst     = 1'b1;
        last_pc = 8'd0;
        tick();
        idle_start("post_reset_start");

        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            tick();
            guard++;
        end
        check("scoreboard_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
